// File: rtl/or_8way.sv
// or_8way: eight-input OR reduction over single-bit flags a..h.
//
// Packed view of the inputs is {a,b,c,d,e,f,g,h}: a is bit 7, h is bit 0.
//
// Ports:
//   clk        rising-edge clock for every registered output
//   rst_n      synchronous active-low reset, sampled on rising clk
//   a..h       single-bit flags (a = index 7 .. h = index 0)
//   sticky_clr synchronous clear for sticky_q (ignored when the sticky build is off)
//   y          combinational OR of all eight inputs, independent of clk/rst_n
//   y_q        y registered, one-cycle latency
//   idx_q      index of the most significant set input, registered (0 when none set;
//              qualify with y_q)
//   cnt_q      number of set inputs, 0..8, registered
//   sticky_q   "any input seen" flag since the last clear/reset
//
// Build option: define OR8WAY_STICKY_EN to enable sticky_q; otherwise it is
// tied to 0 and sticky_clr is unused. The port list is the same either way.

module or_8way (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       a,
    input  logic       b,
    input  logic       c,
    input  logic       d,
    input  logic       e,
    input  logic       f,
    input  logic       g,
    input  logic       h,
    input  logic       sticky_clr,
    output logic       y,
    output logic       y_q,
    output logic [2:0] idx_q,
    output logic [3:0] cnt_q,
    output logic       sticky_q
);

    localparam int unsigned N_IN  = 8;
    localparam int unsigned IDX_W = 3;
    localparam int unsigned CNT_W = 4;

    logic [N_IN-1:0]  in_vec;
    logic [IDX_W-1:0] idx_c;
    logic [CNT_W-1:0] cnt_c;

    assign in_vec = {a, b, c, d, e, f, g, h};

    // Combinational reduction, deliberately outside any reset.
    assign y = |in_vec;

    // Highest set bit: ascending scan so the last hit is the most significant.
    always_comb begin
        idx_c = '0;
        for (int i = 0; i < N_IN; i++) begin
            if (in_vec[i]) begin
                idx_c = IDX_W'(i);
            end
        end
    end

    // Population count; 4 bits so an all-ones input reports 8.
    always_comb begin
        cnt_c = '0;
        for (int i = 0; i < N_IN; i++) begin
            cnt_c = cnt_c + CNT_W'(in_vec[i]);
        end
    end

    // Registered companions of the combinational results.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            y_q   <= 1'b0;
            idx_q <= '0;
            cnt_q <= '0;
        end else begin
            y_q   <= y;
            idx_q <= idx_c;
            cnt_q <= cnt_c;
        end
    end

`ifdef OR8WAY_STICKY_EN
    // Sticky any-seen flag; a clear on the same edge as a new hit wins.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sticky_q <= 1'b0;
        end else if (sticky_clr) begin
            sticky_q <= 1'b0;
        end else begin
            sticky_q <= sticky_q | y;
        end
    end
`else
    logic unused_sticky_clr;

    assign unused_sticky_clr = sticky_clr;
    assign sticky_q          = 1'b0;
`endif

endmodule

// File: tb/tb_or_8way.sv
// Scoreboard bench for or_8way: stimulus pushes expected registered results
// (from a behavioural model) tagged with the cycle they must appear in; a
// monitor on the falling edge pops and compares them.

module tb_or_8way;

    logic       clk;
    logic       rst_n;
    logic       a, b, c, d, e, f, g, h;
    logic       sticky_clr;
    logic       y;
    logic       y_q;
    logic [2:0] idx_q;
    logic [3:0] cnt_q;
    logic       sticky_q;

    or_8way dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .a          (a),
        .b          (b),
        .c          (c),
        .d          (d),
        .e          (e),
        .f          (f),
        .g          (g),
        .h          (h),
        .sticky_clr (sticky_clr),
        .y          (y),
        .y_q        (y_q),
        .idx_q      (idx_q),
        .cnt_q      (cnt_q),
        .sticky_q   (sticky_q)
    );

    typedef struct {
        int         cyc;
        logic       yq;
        logic [2:0] idx;
        logic [3:0] cnt;
        logic       st;
    } exp_t;

    exp_t       sb_q[$];
    exp_t       mon_e;
    int         tests;
    int         fails;
    int         cyc;
    logic [7:0] cur_v;
    logic       mon_y_en;
    logic       m_sticky;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
        end
    endtask

    task automatic drive_vec(input logic [7:0] v);
        {a, b, c, d, e, f, g, h} = v;
        cur_v = v;
    endtask

    // Apply inputs for the next edge and record what that edge must produce.
    task automatic step(input logic [7:0] v, input logic rst, input logic clr);
        exp_t x;
        @(posedge clk);
        #1;
        drive_vec(v);
        rst_n      = rst;
        sticky_clr = clr;
        x.cyc = cyc + 1;
        if (!rst) begin
            x.yq     = 1'b0;
            x.idx    = 3'd0;
            x.cnt    = 4'd0;
            m_sticky = 1'b0;
        end else begin
            x.yq  = (v != 8'd0);
            x.cnt = 4'($countones(v));
            x.idx = (v == 8'd0) ? 3'd0 : 3'($clog2(int'(v) + 1) - 1);
`ifdef OR8WAY_STICKY_EN
            m_sticky = clr ? 1'b0 : (m_sticky | (v != 8'd0));
`else
            m_sticky = 1'b0;
`endif
        end
        x.st = m_sticky;
        sb_q.push_back(x);
    endtask

    // Monitor: combinational y against current inputs, then due scoreboard entries.
    always @(negedge clk) begin
        if (mon_y_en) begin
            check("y_live", int'(y), int'(cur_v != 8'd0));
        end
        while (sb_q.size() > 0 && sb_q[0].cyc <= cyc) begin
            mon_e = sb_q.pop_front();
            check("sb_cycle", mon_e.cyc, cyc);
            check("y_q", int'(y_q), int'(mon_e.yq));
            check("idx_q", int'(idx_q), int'(mon_e.idx));
            check("cnt_q", int'(cnt_q), int'(mon_e.cnt));
            check("sticky_q", int'(sticky_q), int'(mon_e.st));
        end
    end

    initial begin
        tests      = 0;
        fails      = 0;
        cyc        = 0;
        mon_y_en   = 1'b0;
        m_sticky   = 1'b0;
        rst_n      = 1'b0;
        sticky_clr = 1'b0;
        drive_vec(8'd0);

        // Exhaustive combinational sweep, while reset is held.
        for (int i = 0; i < 256; i++) begin
            drive_vec(8'(i));
            #1;
            check("y_sweep", int'(y), (i != 0) ? 1 : 0);
        end
        mon_y_en = 1'b1;

        // Reset state.
        step(8'h00, 1'b0, 1'b0);
        step(8'h00, 1'b0, 1'b0);

        // Directed patterns.
        step(8'b0000_0001, 1'b1, 1'b0);
        step(8'b1111_1111, 1'b1, 1'b0);
        step(8'b0010_0100, 1'b1, 1'b0);
        step(8'b0000_0000, 1'b1, 1'b0);
        step(8'b1000_0000, 1'b1, 1'b0);

        // Reset mid-operation with all inputs high: y stays 1.
        step(8'hFF, 1'b1, 1'b0);
        step(8'hFF, 1'b0, 1'b0);
        step(8'hFF, 1'b1, 1'b0);

        // Sticky: clear, pulse e, then idle.
        step(8'h00, 1'b1, 1'b1);
        step(8'b0000_1000, 1'b1, 1'b0);
        step(8'h00, 1'b1, 1'b0);
        step(8'h00, 1'b1, 1'b0);
        step(8'h00, 1'b1, 1'b0);
        // Clear together with y = 1.
        step(8'hFF, 1'b1, 1'b1);
        step(8'h00, 1'b1, 1'b0);

        // Randomised traffic with occasional clears and resets.
        for (int i = 0; i < 400; i++) begin
            step(8'($urandom), ($urandom_range(0, 31) != 0), ($urandom_range(0, 7) == 0));
        end
        step(8'h00, 1'b1, 1'b0);

        repeat (3) @(posedge clk);
        @(negedge clk);
        #1;
        check("sb_drain", sb_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/or_8way.md
Name: or_8way

Overview:
- 8-input OR reduction block for single-bit flags a..h.
- Combinational output y = a|b|c|d|e|f|g|h, usable with no clock edge.
- Registered companions: y_q, first-set index and population count, for timing-clean use downstream.
- Used wherever "any of eight requests/flags active" is needed.

Parameters:
- None; width fixed at 8 single-bit inputs.

Ports:
- clk  input  1  rising-edge clock for all registered outputs
- rst_n  input  1  synchronous active-low reset, sampled on rising clk
- a  input  1  input bit, index 7 (MSB of the packed vector {a,b,c,d,e,f,g,h})
- b  input  1  input bit, index 6
- c  input  1  input bit, index 5
- d  input  1  input bit, index 4
- e  input  1  input bit, index 3
- f  input  1  input bit, index 2
- g  input  1  input bit, index 1
- h  input  1  input bit, index 0 (LSB)
- y  output  1  combinational OR of all eight inputs
- y_q  output  1  y registered, 1-cycle latency
- idx_q  output  3  index of the highest set bit in {a..h} (a=7 .. h=0), registered
- cnt_q  output  4  number of set inputs, 0..8, registered
- sticky_q  output  1  sticky "any seen" flag (see Optional Feature)
- sticky_clr  input  1  synchronous clear for sticky_q

Behaviour:
- Clocking and reset: one clock domain, clk; rst_n is synchronous and active-low.
- y: purely combinational; y = 1 iff at least one input is 1; y = 0 only when all 8 inputs are 0.
  - Independent of clk and rst_n, including during reset.
- On a rising clk with rst_n = 0: y_q = 0, idx_q = 0, cnt_q = 0, sticky_q = 0.
- On a rising clk with rst_n = 1:
  - y_q <= y.
  - cnt_q <= popcount({a..h}); 4 bits so that 8 is representable.
  - idx_q <= position of the most significant 1 in {a,b,c,d,e,f,g,h}.
    - All-zero input: idx_q <= 0; qualify with y_q = 0.
    - Input with only h set also gives idx_q = 0 but y_q = 1.
- Registered-output latency: exactly 1 cycle from input change to registered output.
- No handshake; inputs are sampled every cycle.
- Reset mid-operation: the registered outputs go to 0 on the next edge; y keeps tracking the inputs.
- X/Z inputs are not handled; inputs must be 0 or 1.

Optional Feature:
- Macro: OR8WAY_STICKY_EN.
- Defined: on each rising clk with rst_n = 1:
  - sticky_clr = 1: sticky_q <= 0. Clear wins over a simultaneous y = 1.
  - Otherwise: sticky_q <= sticky_q | y.
- Not defined: sticky_q is held constant 0 and sticky_clr is ignored.
- The port list is identical in both builds.

Test Plan:
- Exhaustive sweep i = 0..255, {a..h} = i[7:0], 1 time unit per step, no clock required:
  - y = 0 only for i = 0; y = 1 for all other 255 values.
- Clocked, rst_n = 1, inputs = 8'b0000_0001 (h only):
  - after 1 edge: y_q = 1, idx_q = 0, cnt_q = 1.
- Inputs = 8'b1111_1111:
  - after 1 edge: y_q = 1, idx_q = 7, cnt_q = 8.
- Inputs = 8'b0010_0100:
  - after 1 edge: idx_q = 5, cnt_q = 2.
- Hold inputs = 8'hFF, drive rst_n = 0 for 1 edge:
  - y_q = idx_q = cnt_q = sticky_q = 0, while y stays 1.
- With OR8WAY_STICKY_EN:
  - pulse e = 1 for one cycle then all inputs 0: sticky_q stays 1.
  - assert sticky_clr and y = 1 on the same edge: sticky_q = 0.
- Without OR8WAY_STICKY_EN: the same stimulus leaves sticky_q = 0 throughout.
